cla_add_sequencer: RTL and testbench

CLA_ADD_SEQUENCER -- requirements
Module: cla_add_sequencer

---
 rtl/cla_add_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cla_add_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: multi-byte adder that reuses one 8-bit carry-lookahead
// adder across all bytes of the operands, one byte per clock, LSB first.
//
// Optional feature macro: CLA_ADD_SEQUENCER_SUB_EN
//   defined   -> sub=1 computes op_a - op_b (cin ignored, cout=1 means no borrow)
//   undefined -> add-only, sub is ignored
//
// Ports (cla_add_sequencer):
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_valid  operand set present         start_ready  operands accepted in IDLE
//   op_a, op_b   operands (8*NBYTES bits)    cin, sub     carry-in, subtract request
//   res_valid    result present              res_ready    consumer accepts result
//   result       sum/difference              cout, ovf    carry out, signed overflow
//   busy         high while RUN or DONE
//
// Ports (cla_8bit): a, b, cin -> sum, cout (8-bit carry-lookahead adder)

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat function of g/p/cin; the loop expands to the
  // lookahead terms rather than a physical ripple chain.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for operands; last result/cout/ovf still visible
// RUN   | one byte added per cycle, byte index k walks 0..NBYTES-1
// DONE  | result valid and frozen until res_ready handshake
module cla_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);
  localparam int KW = (NBYTES > 2) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [8*NBYTES-1:0] a_reg;
  logic [8*NBYTES-1:0] b_reg;
  logic [KW-1:0]       k;
  logic                carry;
  logic                accept;
  logic                last;
  logic                init_carry;
  logic [7:0]          mask;
  logic [7:0]          a_byte;
  logic [7:0]          b_byte;
  logic [7:0]          sum_byte;
  logic                co_byte;
  logic                c_into_msb;

`ifdef CLA_ADD_SEQUENCER_SUB_EN
  logic sub_reg;
  // Two's-complement subtract: invert B and force the initial carry to 1.
  assign init_carry = sub ? 1'b1 : cin;
  assign mask       = sub_reg ? 8'hFF : 8'h00;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign init_carry = cin;
  assign mask       = 8'h00;
`endif

  assign accept      = (state == IDLE) && start_valid;
  assign last        = (k == KW'(NBYTES - 1));
  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == KW'(i)) begin
        a_byte = a_reg[8*i +: 8];
        b_byte = b_reg[8*i +: 8] ^ mask;
      end
    end
  end

  cla_8bit u_cla (a_byte, b_byte, carry, sum_byte, co_byte);

  // Carry into bit 7 of the current byte, recovered from the sum bit.
  assign c_into_msb = sum_byte[7] ^ a_byte[7] ^ b_byte[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      k       <= '0;
      carry   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg   <= op_a;
      b_reg   <= op_b;
      k       <= '0;
      carry   <= init_carry;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
      sub_reg <= sub;
`endif
    end else if (state == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (k == KW'(i)) result[8*i +: 8] <= sum_byte;
      end
      carry <= co_byte;
      k     <= k + KW'(1);
      if (last) begin
        cout <= co_byte;
        ovf  <= c_into_msb ^ co_byte;
      end
    end
  end
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer (NBYTES=4). Expected values are
// hand-computed constants; subtract expectations follow the build macro.
module tb_cla_add_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  cla_add_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Launch one operation, scramble the operand inputs right after the accept
  // edge, and return the result once res_valid is seen (bounded wait).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s,
                        output logic [31:0] r, output logic co,
                        output logic ov, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a = ~a; op_b = b ^ 32'h5A5A5A5A; cin = ~c; sub = ~s;
    lat = 0;
    while (lat < 20 && !res_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result; co = cout; ov = ovf;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({result, cout, ovf, res_valid, busy, start_ready} !== {32'h0, 5'b00001}) begin
      fails++;
      $display("FAIL reset_state: got result=%h cout=%b ovf=%b rv=%b busy=%b sr=%b, want 0 0 0 0 0 1",
               result, cout, ovf, res_valid, busy, start_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // res_ready while nothing is valid must do nothing
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if ({res_valid, busy, start_ready} !== 3'b001 || result !== 32'h0) begin
      fails++;
      $display("FAIL idle_res_ready: got rv=%b busy=%b sr=%b result=%h, want 0 0 1 0",
               res_valid, busy, start_ready, result);
    end
  endtask

  task automatic test_add();
    logic [31:0] r; logic co, ov; int lat;
    // byte 0 carry into byte 1
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    tests++;
    if (lat != 4) begin fails++; $display("FAIL latency: got %0d cycles, want 4", lat); end
    tests++;
    if ({r, co, ov} !== {32'h00000100, 2'b00}) begin
      fails++; $display("FAIL add_ff_1: got %h c=%b v=%b, want 00000100 c=0 v=0", r, co, ov);
    end
    tests++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      fails++; $display("FAIL done_flags: got busy=%b sr=%b, want 1 0", busy, start_ready);
    end
    ack();
    // cin ripples through every byte
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {32'h00000000, 2'b10} || lat != 4) begin
      fails++; $display("FAIL ripple_cin: got %h c=%b v=%b lat=%0d, want 00000000 c=1 v=0 lat=4", r, co, ov, lat);
    end
    ack();
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {32'h23456789, 2'b00}) begin
      fails++; $display("FAIL add_plain: got %h c=%b v=%b, want 23456789 c=0 v=0", r, co, ov);
    end
    ack();
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic co, ov; int lat;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {32'h80000000, 2'b01}) begin
      fails++; $display("FAIL ovf_pos: got %h c=%b v=%b, want 80000000 c=0 v=1", r, co, ov);
    end
    ack();
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {32'h00000000, 2'b11}) begin
      fails++; $display("FAIL ovf_neg: got %h c=%b v=%b, want 00000000 c=1 v=1", r, co, ov);
    end
    ack();
  endtask

  task automatic test_hold();
    logic [31:0] r; logic co, ov; int lat;
    int bad;
    run_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, r, co, ov, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_a = 32'hDEAD0000 + i; op_b = 32'h0000BEEF; start_valid = i[0];
      if (result !== 32'h00000030 || res_valid !== 1'b1 || start_ready !== 1'b0) bad++;
    end
    @(negedge clk);
    start_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL hold_stable: got %0d bad cycles, result=%h rv=%b sr=%b, want 0 bad", bad, result, res_valid, start_ready);
    end
    ack();
    tests++;
    if ({res_valid, busy, start_ready} !== 3'b001 || result !== 32'h00000030) begin
      fails++; $display("FAIL hold_release: got rv=%b busy=%b sr=%b result=%h, want 0 0 1 00000030",
                        res_valid, busy, start_ready, result);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r; logic co, ov; int lat;
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({result, cout, ovf, res_valid, busy, start_ready} !== {32'h0, 5'b00001}) begin
      fails++;
      $display("FAIL reset_mid_run: got result=%h cout=%b ovf=%b rv=%b busy=%b sr=%b, want 0 0 0 0 0 1",
               result, cout, ovf, res_valid, busy, start_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {32'h00000002, 2'b00} || lat != 4) begin
      fails++; $display("FAIL after_reset: got %h c=%b v=%b lat=%0d, want 00000002 c=0 v=0 lat=4", r, co, ov, lat);
    end
    ack();
  endtask

  task automatic test_sub();
    logic [31:0] r; logic co, ov; int lat;
    logic [31:0] exp_r;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
    exp_r = 32'hFFFFFFFE;
`else
    exp_r = 32'h0000000C;
`endif
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, r, co, ov, lat);
    tests++;
    if ({r, co, ov} !== {exp_r, 2'b00}) begin
      fails++; $display("FAIL sub_5_7: got %h c=%b v=%b, want %h c=0 v=0", r, co, ov, exp_r);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_hold();
    test_reset_mid_run();
    test_sub();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
